// File: rtl/multicycle_pkg.sv
// Shared definitions for the interrupt-capable multicycle control FSM:
// state codes, opcode classification, function codes and ALU select mapping.
package multicycle_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_INT    = 3'd5;
  localparam state_t ST_SLEEP  = 3'd6;

  localparam logic [2:0] FN_WAIT = 3'b100;
  localparam logic [2:0] FN_STBY = 3'b101;
  localparam logic [2:0] FN_RETI = 3'b001;

  localparam logic [1:0] MEM_LD  = 2'b00;
  localparam logic [1:0] MEM_ST  = 2'b01;
  localparam logic [1:0] MEM_IN  = 2'b10;
  localparam logic [1:0] MEM_OUT = 2'b11;

  localparam logic [3:0] ALU_NOP      = 4'b0000;
  localparam logic [1:0] ALU_SHIFT_HI = 2'b10;

  typedef struct packed {
    logic branch;
    logic jump;
    logic misc;
    logic mem;
    logic shift;
    logic alu_reg;
    logic alu_imm;
  } op_class_t;

  // Classes are mutually exclusive; 1111111 matches none and decodes as a NOP.
  function automatic op_class_t decode_class(input logic [6:0] op);
    op_class_t c;
    c.branch  = (op[6:1] == 6'b111110);
    c.jump    = (op[6:2] == 5'b11110);
    c.misc    = (op == 7'b1111110);
    c.mem     = (op[6:5] == 2'b10);
    c.shift   = (op[6:4] == 3'b110);
    c.alu_reg = (op[6:3] == 4'b1110);
    c.alu_imm = (op[6] == 1'b0);
    return c;
  endfunction

  function automatic logic [3:0] alu_map(input op_class_t c, input logic [2:0] func);
    logic [3:0] r;
    if (c.alu_imm || c.alu_reg) begin
      if ((func == 3'b011) || (func == 3'b100)) begin
        r = ALU_NOP;
      end else begin
        r = {1'b0, func};
      end
    end else if (c.shift) begin
      r = {ALU_SHIFT_HI, func[1:0]};
    end else begin
      r = ALU_NOP;
    end
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_irq_prio_enc.sv
// Masked priority encoder: the lowest-index enabled request wins.
module irq_prio_enc #(
  parameter int NUM_IRQ = 4,
  parameter int VW      = $clog2(NUM_IRQ + 1)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] mask,
  output logic               valid,
  output logic [VW-1:0]      vec
);

  logic [NUM_IRQ-1:0] act_s;

  assign act_s = req & mask;
  assign valid = |act_s;

  // Scan from the top down so the lowest active index is assigned last.
  always_comb begin
    vec = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      vec = act_s[i] ? VW'(i) : vec;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_irq.sv
// Multicycle control FSM with masked prioritised interrupts, bus acks,
// a bus-timeout trap, a WAIT/STBY sleep state and a global interrupt enable.
module multicycle_ctrl_irq
  import multicycle_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int TIMEOUT = 15,
  parameter int ERR_VEC = NUM_IRQ,
  localparam int VW = $clog2(NUM_IRQ + 1),
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op_i,
  input  logic [2:0]         func_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic               inst_ack_i,
  input  logic               data_ack_i,
  input  logic               port_ack_i,
  output logic [3:0]         alu_op_o,
  output logic               op2_sel_o,
  output logic [1:0]         reg_mux_o,
  output logic               reg_wrt_o,
  output logic               alu_en_o,
  output logic               alu_fr_o,
  output logic               pc_en_o,
  output logic               dp_mux_o,
  output logic               inst_stb_o,
  output logic               inst_cyc_o,
  output logic               data_stb_o,
  output logic               data_cyc_o,
  output logic               data_we_o,
  output logic               port_stb_o,
  output logic               port_we_o,
  output logic               reti_o,
  output logic               int_ack_o,
  output logic [VW-1:0]      int_vec_o,
  output logic               ie_o,
  output logic               bus_err_o
);

  localparam logic TMO_EN = (TIMEOUT != 0);

  state_t        state_r;
  state_t        state_nxt_s;
  logic          ie_r;
  logic          bus_err_r;
  logic          err_int_r;
  logic [CW-1:0] tmo_cnt_r;

  op_class_t     cls_s;
  logic [1:0]    mem_op_s;
  logic          is_reti_s;
  logic          is_sleep_s;
  logic          irq_valid_s;
  logic [VW-1:0] irq_vec_s;
  logic          pend_s;
  logic          in_bus_s;
  logic          bus_ack_s;
  logic          tmo_fire_s;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .VW      (VW)
  ) u_prio (
    .req   (irq_i),
    .mask  (irq_mask_i),
    .valid (irq_valid_s),
    .vec   (irq_vec_s)
  );

  assign cls_s      = decode_class(op_i);
  assign mem_op_s   = func_i[2:1];
  assign is_reti_s  = cls_s.misc && (func_i == FN_RETI);
  assign is_sleep_s = cls_s.misc && ((func_i == FN_WAIT) || (func_i == FN_STBY));
  assign pend_s     = irq_valid_s && ie_r;
  assign in_bus_s   = (state_r == ST_FETCH) || (state_r == ST_MEM);
  // An ack in the final counted cycle beats the timeout.
  assign tmo_fire_s = TMO_EN && in_bus_s && !bus_ack_s && (tmo_cnt_r == CW'(TIMEOUT));
  assign ie_o       = ie_r;
  assign bus_err_o  = bus_err_r;

  // Ack relevant to the bus owned by the current state.
  always_comb begin
    bus_ack_s = 1'b0;
    case (state_r)
      ST_FETCH: bus_ack_s = inst_ack_i;
      ST_MEM:   bus_ack_s = mem_op_s[1] ? port_ack_i : data_ack_i;
      default:  bus_ack_s = 1'b0;
    endcase
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (tmo_fire_s) begin
          state_nxt_s = ST_INT;
        end else if (inst_ack_i) begin
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_sleep_s) begin
          state_nxt_s = ST_SLEEP;
        end else if (cls_s.branch || cls_s.jump || cls_s.misc) begin
          state_nxt_s = pend_s ? ST_INT : ST_FETCH;
        end else if (cls_s.alu_imm || cls_s.alu_reg || cls_s.shift || cls_s.mem) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_EXEC: state_nxt_s = cls_s.mem ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (tmo_fire_s) begin
          state_nxt_s = ST_INT;
        end else if (bus_ack_s) begin
          if (!mem_op_s[0]) begin
            state_nxt_s = ST_WB;
          end else begin
            state_nxt_s = pend_s ? ST_INT : ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB:    state_nxt_s = pend_s ? ST_INT : ST_FETCH;
      ST_SLEEP: state_nxt_s = pend_s ? ST_INT : ST_SLEEP;
      ST_INT:   state_nxt_s = ST_FETCH;
      default:  state_nxt_s = ST_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus-wait counter, cleared whenever the FSM is not stalled on a bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if (TMO_EN && in_bus_s && !bus_ack_s && !tmo_fire_s) begin
      tmo_cnt_r <= tmo_cnt_r + CW'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  // Interrupt enable, sticky bus error and the error cause for the INT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_r      <= 1'b1;
      bus_err_r <= 1'b0;
      err_int_r <= 1'b0;
    end else begin
      err_int_r <= tmo_fire_s;
      if (tmo_fire_s) begin
        bus_err_r <= 1'b1;
      end else if ((state_r == ST_DECODE) && is_reti_s) begin
        bus_err_r <= 1'b0;
      end else begin
        bus_err_r <= bus_err_r;
      end
      if (state_r == ST_INT) begin
        ie_r <= 1'b0;
      end else if ((state_r == ST_DECODE) && is_reti_s) begin
        ie_r <= 1'b1;
      end else begin
        ie_r <= ie_r;
      end
    end
  end

  // Output decode from state and instruction fields.
  always_comb begin
    alu_op_o   = ALU_NOP;
    op2_sel_o  = 1'b0;
    reg_mux_o  = 2'b00;
    reg_wrt_o  = 1'b0;
    alu_en_o   = 1'b0;
    alu_fr_o   = 1'b0;
    pc_en_o    = 1'b0;
    dp_mux_o   = 1'b0;
    inst_stb_o = 1'b0;
    inst_cyc_o = 1'b0;
    data_stb_o = 1'b0;
    data_cyc_o = 1'b0;
    data_we_o  = 1'b0;
    port_stb_o = 1'b0;
    port_we_o  = 1'b0;
    reti_o     = 1'b0;
    int_ack_o  = 1'b0;
    int_vec_o  = '0;
    case (state_r)
      ST_FETCH: begin
        inst_stb_o = 1'b1;
        inst_cyc_o = 1'b1;
        pc_en_o    = 1'b1;
      end
      ST_DECODE, ST_EXEC, ST_WB: begin
        alu_op_o  = alu_map(cls_s, func_i);
        op2_sel_o = cls_s.alu_reg;
        reg_mux_o = {1'b0, cls_s.mem && !mem_op_s[0]};
        dp_mux_o  = cls_s.mem;
        reti_o    = (state_r == ST_DECODE) && is_reti_s;
        alu_en_o  = (state_r == ST_EXEC) && !cls_s.mem;
        alu_fr_o  = (state_r == ST_EXEC) && !cls_s.mem;
        reg_wrt_o = (state_r == ST_WB);
      end
      ST_MEM: begin
        dp_mux_o   = cls_s.mem;
        data_stb_o = !mem_op_s[1];
        data_cyc_o = !mem_op_s[1];
        data_we_o  = (mem_op_s == MEM_ST);
        port_stb_o = mem_op_s[1];
        port_we_o  = (mem_op_s == MEM_OUT);
      end
      ST_INT: begin
        int_ack_o = 1'b1;
        int_vec_o = err_int_r ? VW'(ERR_VEC) : irq_vec_s;
      end
      ST_SLEEP: int_ack_o = 1'b0;
      default:  int_ack_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_irq.sv
// Directed and randomised instruction streams checked cycle by cycle against
// a per-instruction phase model built from the opcode/func/ack rules.
module tb_multicycle_ctrl_irq;

  localparam int NUM_IRQ = 4;
  localparam int TIMEOUT = 15;
  localparam int ERR_VEC = 4;
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_INT = 5, P_SLEEP = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op_i = 7'd0;
  logic [2:0] func_i = 3'd0;
  logic [3:0] irq_i = 4'd0;
  logic [3:0] irq_mask_i = 4'd0;
  logic       inst_ack_i = 1'b0;
  logic       data_ack_i = 1'b0;
  logic       port_ack_i = 1'b0;
  logic [3:0] alu_op_o;
  logic       op2_sel_o;
  logic [1:0] reg_mux_o;
  logic       reg_wrt_o, alu_en_o, alu_fr_o, pc_en_o, dp_mux_o;
  logic       inst_stb_o, inst_cyc_o, data_stb_o, data_cyc_o, data_we_o;
  logic       port_stb_o, port_we_o, reti_o, int_ack_o;
  logic [2:0] int_vec_o;
  logic       ie_o, bus_err_o;

  always #5 clk = ~clk;

  multicycle_ctrl_irq #(
    .NUM_IRQ (NUM_IRQ),
    .TIMEOUT (TIMEOUT),
    .ERR_VEC (ERR_VEC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op_i       (op_i),
    .func_i     (func_i),
    .irq_i      (irq_i),
    .irq_mask_i (irq_mask_i),
    .inst_ack_i (inst_ack_i),
    .data_ack_i (data_ack_i),
    .port_ack_i (port_ack_i),
    .alu_op_o   (alu_op_o),
    .op2_sel_o  (op2_sel_o),
    .reg_mux_o  (reg_mux_o),
    .reg_wrt_o  (reg_wrt_o),
    .alu_en_o   (alu_en_o),
    .alu_fr_o   (alu_fr_o),
    .pc_en_o    (pc_en_o),
    .dp_mux_o   (dp_mux_o),
    .inst_stb_o (inst_stb_o),
    .inst_cyc_o (inst_cyc_o),
    .data_stb_o (data_stb_o),
    .data_cyc_o (data_cyc_o),
    .data_we_o  (data_we_o),
    .port_stb_o (port_stb_o),
    .port_we_o  (port_we_o),
    .reti_o     (reti_o),
    .int_ack_o  (int_ack_o),
    .int_vec_o  (int_vec_o),
    .ie_o       (ie_o),
    .bus_err_o  (bus_err_o)
  );

  typedef struct packed {
    logic       inst_stb, inst_cyc, pc_en, alu_en, alu_fr, reg_wrt, dp_mux, op2_sel;
    logic [1:0] reg_mux;
    logic [3:0] alu_op;
    logic       data_stb, data_cyc, data_we, port_stb, port_we, reti, int_ack;
    logic [2:0] int_vec;
    logic       ie, bus_err;
  } outs_t;

  outs_t obs;
  assign obs = '{inst_stb: inst_stb_o, inst_cyc: inst_cyc_o, pc_en: pc_en_o, alu_en: alu_en_o,
                 alu_fr: alu_fr_o, reg_wrt: reg_wrt_o, dp_mux: dp_mux_o, op2_sel: op2_sel_o,
                 reg_mux: reg_mux_o, alu_op: alu_op_o, data_stb: data_stb_o, data_cyc: data_cyc_o,
                 data_we: data_we_o, port_stb: port_stb_o, port_we: port_we_o, reti: reti_o,
                 int_ack: int_ack_o, int_vec: int_vec_o, ie: ie_o, bus_err: bus_err_o};

  int checks = 0;
  int errors = 0;
  bit m_ie = 1'b1;
  bit m_err = 1'b0;

  // 0 branch, 1 jump, 2 misc, 3 mem, 4 shift, 5 alu_reg, 6 alu_imm, 7 undefined
  function automatic int cls_of(logic [6:0] op);
    int o = int'(op);
    if (o < 64) return 6;
    if (o < 96) return 3;
    if (o < 112) return 4;
    if (o < 120) return 5;
    if (o < 124) return 1;
    if (o < 126) return 0;
    if (o == 126) return 2;
    return 7;
  endfunction

  function automatic logic [2:0] lowest(logic [3:0] a);
    for (int i = 0; i < 4; i++) begin
      if (a[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  function automatic outs_t expect_out(int ph, logic [6:0] op, logic [2:0] fn, logic [2:0] vec);
    outs_t e = '0;
    int c = cls_of(op);
    int f = int'(fn);
    e.ie = m_ie;
    e.bus_err = m_err;
    if (ph == P_FETCH) begin
      e.inst_stb = 1'b1; e.inst_cyc = 1'b1; e.pc_en = 1'b1;
    end else if (ph == P_DECODE || ph == P_EXEC || ph == P_WB) begin
      if (c == 5 || c == 6) e.alu_op = (f == 3 || f == 4) ? 4'd0 : 4'(f);
      else if (c == 4) e.alu_op = 4'(8 + f % 4);
      e.op2_sel = (c == 5);
      e.dp_mux = (c == 3);
      e.reg_mux = (c == 3 && (f / 2) % 2 == 0) ? 2'd1 : 2'd0;
      e.reti = (ph == P_DECODE) && (c == 2) && (f == 1);
      e.alu_en = (ph == P_EXEC) && (c != 3);
      e.alu_fr = (ph == P_EXEC) && (c != 3);
      e.reg_wrt = (ph == P_WB);
    end else if (ph == P_MEM) begin
      e.dp_mux = 1'b1;
      if (f < 4) begin
        e.data_stb = 1'b1; e.data_cyc = 1'b1; e.data_we = (f / 2 == 1);
      end else begin
        e.port_stb = 1'b1; e.port_we = (f / 2 == 3);
      end
    end else if (ph == P_INT) begin
      e.int_ack = 1'b1; e.int_vec = vec;
    end
    return e;
  endfunction

  task automatic step(string tag, outs_t e);
    @(negedge clk);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic take_int(string tag, logic [2:0] vec);
    step({tag, ":int"}, expect_out(P_INT, 7'd0, 3'd0, vec));
    m_ie = 1'b0;
  endtask

  task automatic do_instr(string tag, logic [6:0] op, logic [2:0] fn, int fdel, int mdel,
                          logic [3:0] irq, logic [3:0] msk, int sleep_n, logic [3:0] wake, int rst_at);
    int c = cls_of(op);
    int lim = TIMEOUT + 1;
    bit pend;
    op_i = op; func_i = fn; irq_i = irq; irq_mask_i = msk;
    for (int k = 1; k <= lim && k <= fdel; k++) begin
      inst_ack_i = (k == fdel);
      step({tag, ":fetch"}, expect_out(P_FETCH, op, fn, 3'd0));
    end
    inst_ack_i = 1'b0;
    if (fdel > lim) begin
      m_err = 1'b1;
      take_int({tag, ":ftmo"}, 3'(ERR_VEC));
      return;
    end
    pend = m_ie && ((irq & msk) != 4'd0);
    step({tag, ":decode"}, expect_out(P_DECODE, op, fn, 3'd0));
    if (c == 2 && fn == 3'd1) begin
      m_ie = 1'b1; m_err = 1'b0;
    end
    if (c == 7) return;
    if (c == 2 && (fn == 3'd4 || fn == 3'd5)) begin
      for (int k = 0; k <= sleep_n; k++) begin
        irq_i = (k < sleep_n) ? 4'd0 : wake;
        step({tag, ":sleep"}, expect_out(P_SLEEP, op, fn, 3'd0));
      end
      take_int({tag, ":wake"}, lowest(wake & msk));
      return;
    end
    if (c <= 2) begin
      if (pend) take_int(tag, lowest(irq & msk));
      return;
    end
    step({tag, ":exec"}, expect_out(P_EXEC, op, fn, 3'd0));
    if (c != 3) begin
      step({tag, ":wb"}, expect_out(P_WB, op, fn, 3'd0));
      if (pend) take_int(tag, lowest(irq & msk));
      return;
    end
    for (int k = 1; k <= lim && k <= mdel; k++) begin
      data_ack_i = (fn < 3'd4) && (k == mdel);
      port_ack_i = (fn >= 3'd4) && (k == mdel);
      rst = (k == rst_at);
      step({tag, ":mem"}, expect_out(P_MEM, op, fn, 3'd0));
      if (k == rst_at) begin
        rst = 1'b0; data_ack_i = 1'b0; port_ack_i = 1'b0;
        m_ie = 1'b1; m_err = 1'b0;
        return;
      end
    end
    data_ack_i = 1'b0; port_ack_i = 1'b0;
    if (mdel > lim) begin
      m_err = 1'b1;
      take_int({tag, ":mtmo"}, 3'(ERR_VEC));
      return;
    end
    if ((int'(fn) / 2) % 2 == 0) begin
      step({tag, ":wb"}, expect_out(P_WB, op, fn, 3'd0));
    end
    if (pend) take_int(tag, lowest(irq & msk));
  endtask

  initial begin
    int c, fd, md, sn, ra;
    logic [6:0] op;
    logic [2:0] fn;
    logic [3:0] irq, msk, wake;

    repeat (2) @(posedge clk);
    #1;
    step("reset", expect_out(P_FETCH, 7'd0, 3'd0, 3'd0));
    rst = 1'b0;

    do_instr("add_reg",    7'b1110000, 3'b000, 1, 0,  4'b0000, 4'b0000, 0, 4'b0000, 0);
    do_instr("ld_ack3",    7'b1000000, 3'b000, 2, 3,  4'b0000, 4'b0000, 0, 4'b0000, 0);
    do_instr("fetch_edge", 7'b0000001, 3'b010, 16, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    do_instr("st_tmo",     7'b1000000, 3'b010, 1, 99, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    do_instr("reti1",      7'b1111110, 3'b001, 1, 0,  4'b0000, 4'b0000, 0, 4'b0000, 0);
    do_instr("wait",       7'b1111110, 3'b100, 1, 0,  4'b0000, 4'b1111, 3, 4'b0110, 0);
    do_instr("reti2",      7'b1111110, 3'b001, 1, 0,  4'b0000, 4'b1111, 0, 4'b0000, 0);
    do_instr("out_masked", 7'b1000000, 3'b110, 1, 4,  4'b0001, 4'b0000, 0, 4'b0000, 0);
    do_instr("br_irq",     7'b1111101, 3'b000, 1, 0,  4'b1010, 4'b1000, 0, 4'b0000, 0);
    do_instr("reti3",      7'b1111110, 3'b001, 1, 0,  4'b0000, 4'b0000, 0, 4'b0000, 0);
    do_instr("in_edge",    7'b1000000, 3'b100, 1, 16, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    do_instr("fetch_tmo",  7'b1100101, 3'b011, 17, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    do_instr("undef",      7'b1111111, 3'b000, 1, 0,  4'b1111, 4'b1111, 0, 4'b0000, 0);
    do_instr("reti4",      7'b1111110, 3'b001, 1, 0,  4'b0000, 4'b0000, 0, 4'b0000, 0);
    do_instr("rst_mem",    7'b1000000, 3'b000, 1, 99, 4'b0000, 4'b0000, 0, 4'b0000, 5);

    for (int n = 0; n < 250; n++) begin
      c = $urandom_range(0, 7);
      case (c)
        0:       op = 7'b1111100 | 7'($urandom_range(0, 1));
        1:       op = 7'b1111000 | 7'($urandom_range(0, 3));
        2:       op = 7'b1111110;
        3:       op = 7'b1000000 | 7'($urandom_range(0, 31));
        4:       op = 7'b1100000 | 7'($urandom_range(0, 15));
        5:       op = 7'b1110000 | 7'($urandom_range(0, 7));
        6:       op = 7'($urandom_range(0, 63));
        default: op = 7'b1111111;
      endcase
      fn   = 3'($urandom_range(0, 7));
      fd   = ($urandom_range(0, 15) == 0) ? 17 : $urandom_range(1, 4);
      md   = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(1, 5);
      irq  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      msk  = 4'($urandom_range(0, 15));
      sn   = $urandom_range(0, 3);
      wake = 4'($urandom_range(1, 15));
      ra   = ($urandom_range(0, 19) == 0) ? 1 : 0;
      if (c == 2 && $urandom_range(0, 1) == 1) fn = 3'b001;
      if (c == 2 && (fn == 3'd4 || fn == 3'd5) && !(m_ie && ((wake & msk) != 4'd0))) fn = 3'b001;
      do_instr($sformatf("r%0d", n), op, fn, fd, md, irq, msk, sn, wake, ra);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
